// File: rtl/counter_ctrl.sv
// counter_ctrl: key/switch conditioning and STEP/RUN/HOLD sequencer
// that issues enable and load strobes to the LED counter register.
module counter_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 25000000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [1:0]       KEY,
    input  logic [3:0]       SW,
    output logic             CNT_EN,
    output logic             CNT_UP,
    output logic             CNT_LOAD,
    output logic [WIDTH-1:0] LOAD_VAL,
    output logic [1:0]       MODE
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        STEP = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    logic [1:0]    key_s1;
    logic [1:0]    key_s2;
    logic [1:0]    key_stable;
    logic [1:0]    press;
    logic [3:0]    sw_s1;
    logic [3:0]    sw_s2;
    logic [DW-1:0] db_cnt [2];

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] tick;
    logic [TW-1:0] tick_n;
    logic          wrap;
    logic          en_n;
    logic          load_n;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            sw_s1  <= 4'b0000;
            sw_s2  <= 4'b0000;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // press is a registered one-cycle pulse on an accepted 1->0 change
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_stable <= 2'b11;
            press      <= 2'b00;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (key_s2[i] == key_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    key_stable[i] <= key_s2[i];
                    press[i]      <= key_stable[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign wrap = (tick == TICK_MAX);

    // a mode press always wins over an action press or a tick wrap
    always_comb begin
        state_n = state;
        tick_n  = '0;
        en_n    = 1'b0;
        load_n  = 1'b0;
        case (state)
            STEP: begin
                if (press[1]) state_n = RUN;
                else          en_n    = press[0];
            end
            RUN: begin
                if (press[1]) begin
                    state_n = HOLD;
                end else begin
                    tick_n = wrap ? '0 : tick + 1'b1;
                    en_n   = wrap;
                end
            end
            HOLD: begin
                if (press[1]) state_n = STEP;
                else          load_n  = press[0];
            end
            default: state_n = STEP;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= STEP;
            tick     <= '0;
            CNT_EN   <= 1'b0;
            CNT_LOAD <= 1'b0;
            CNT_UP   <= 1'b0;
            LOAD_VAL <= '0;
        end else begin
            state    <= state_n;
            tick     <= tick_n;
            CNT_EN   <= en_n;
            CNT_LOAD <= load_n;
            CNT_UP   <= sw_s2[0];
            if (load_n) begin
                LOAD_VAL <= {{(WIDTH-3){1'b0}}, sw_s2[3:1]};
            end
        end
    end

    assign MODE = state;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: randomized scenarios against an event-time model
// of the key, mode and tick behaviour of counter_ctrl.
module tb_counter_ctrl;

    localparam int W = 8;
    localparam int D = 4;
    localparam int T = 10;

    logic         CLOCK_50 = 1'b0;
    logic         RESET_N  = 1'b0;
    logic [1:0]   KEY      = 2'b11;
    logic [3:0]   SW       = 4'b0000;
    logic         CNT_EN;
    logic         CNT_UP;
    logic         CNT_LOAD;
    logic [W-1:0] LOAD_VAL;
    logic [1:0]   MODE;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int both   = 0;

    int           en_t[$];
    logic         en_u[$];
    int           ld_t[$];
    logic [W-1:0] ld_v[$];
    int           x_en_t[$];
    logic         x_en_u[$];
    int           x_ld_t[$];
    logic [W-1:0] x_ld_v[$];

    int m_mode = 0;
    int m_next = 0;

    counter_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .TICK_CYCLES(T)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N(RESET_N),
        .KEY(KEY),
        .SW(SW),
        .CNT_EN(CNT_EN),
        .CNT_UP(CNT_UP),
        .CNT_LOAD(CNT_LOAD),
        .LOAD_VAL(LOAD_VAL),
        .MODE(MODE)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (CNT_EN) begin
            en_t.push_back(cyc);
            en_u.push_back(CNT_UP);
        end
        if (CNT_LOAD) begin
            ld_t.push_back(cyc);
            ld_v.push_back(LOAD_VAL);
        end
        if (CNT_EN && CNT_LOAD) both++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Model: an accepted press driven at cycle t0 acts at t0+D+4;
    // RUN strobes fall every T cycles from the cycle RUN was entered.
    function automatic void m_flush(input int upto);
        while (m_mode == 1 && m_next <= upto) begin
            x_en_t.push_back(m_next);
            x_en_u.push_back(SW[0]);
            m_next += T;
        end
    endfunction

    function automatic void m_key0(input int t);
        if (m_mode == 0) begin
            x_en_t.push_back(t);
            x_en_u.push_back(SW[0]);
        end else if (m_mode == 2) begin
            x_ld_t.push_back(t);
            x_ld_v.push_back({5'b00000, SW[3:1]});
        end
    endfunction

    function automatic void m_key1(input int t);
        m_flush(t - 1);
        m_mode = (m_mode + 1) % 3;
        m_next = t + T;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input int k, input int hold, output int t0);
        @(negedge CLOCK_50);
        KEY[k] = 1'b0;
        t0 = cyc;
        repeat (hold) @(negedge CLOCK_50);
        KEY[k] = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        KEY = 2'b11;
        SW = 4'b1010;
        idle(3);
        #1;
        n_run++;
        if ({MODE, CNT_EN, CNT_LOAD, CNT_UP, LOAD_VAL} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0",
                     {MODE, CNT_EN, CNT_LOAD, CNT_UP, LOAD_VAL});
        end
        RESET_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            #1;
            n_run++;
            if ({MODE, CNT_EN, CNT_LOAD, LOAD_VAL} !== 12'd0) begin
                n_fail++;
                $display("FAIL idle_outputs[%0d]: got %b want 0", i,
                         {MODE, CNT_EN, CNT_LOAD, LOAD_VAL});
            end
        end
    endtask

    task automatic test_sw_sync();
        logic prev;
        logic b;
        prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b = 1'($urandom_range(0, 1));
            @(negedge CLOCK_50);
            SW[0] = b;
            idle(2);
            #1;
            n_run++;
            if (CNT_UP !== prev) begin
                n_fail++;
                $display("FAIL up_early[%0d]: got %b want %b", i, CNT_UP, prev);
            end
            @(negedge CLOCK_50);
            #1;
            n_run++;
            if (CNT_UP !== b) begin
                n_fail++;
                $display("FAIL up_latency[%0d]: got %b want %b", i, CNT_UP, b);
            end
            prev = b;
        end
        SW[0] = 1'b0;
        idle(4);
    endtask

    task automatic test_step();
        int t0;
        int h;
        press(0, 30, t0);
        m_key0(t0 + D + 4);
        idle(D + 6);
        press(0, 3, t0);
        idle(D + 6);
        for (int i = 0; i < 8; i++) begin
            SW[0] = 1'($urandom_range(0, 1));
            idle(4);
            if ($urandom_range(0, 2) == 0) h = $urandom_range(1, D - 1);
            else                           h = $urandom_range(D + 2, 20);
            press(0, h, t0);
            if (h > D) m_key0(t0 + D + 4);
            idle($urandom_range(D + 6, 14));
        end
        #1;
        n_run++;
        if (en_t.size() != x_en_t.size()) begin
            n_fail++;
            $display("FAIL step_en_count: got %0d want %0d",
                     en_t.size(), x_en_t.size());
        end else begin
            foreach (x_en_t[i]) begin
                n_run++;
                if (en_t[i] !== x_en_t[i] || en_u[i] !== x_en_u[i]) begin
                    n_fail++;
                    $display("FAIL step_en[%0d]: got cyc %0d up %b want cyc %0d up %b",
                             i, en_t[i], en_u[i], x_en_t[i], x_en_u[i]);
                end
            end
        end
        en_t.delete(); en_u.delete(); x_en_t.delete(); x_en_u.delete();
    endtask

    task automatic test_run();
        int t0;
        int m;
        SW[0] = 1'b1;
        idle(4);
        press(1, $urandom_range(D + 2, 10), t0);
        m = t0 + D + 4;
        m_key1(m);
        while (cyc < m + 5) @(negedge CLOCK_50);
        press(0, $urandom_range(D + 2, 10), t0);
        m_key0(t0 + D + 4);
        while (cyc < m + 55) @(negedge CLOCK_50);
        #1;
        n_run++;
        if (MODE !== 2'b01) begin
            n_fail++;
            $display("FAIL run_mode: got %b want 01", MODE);
        end
        m_flush(cyc);
        n_run++;
        if (en_t.size() != x_en_t.size()) begin
            n_fail++;
            $display("FAIL run_en_count: got %0d want %0d",
                     en_t.size(), x_en_t.size());
        end else begin
            foreach (x_en_t[i]) begin
                n_run++;
                if (en_t[i] !== x_en_t[i] || en_u[i] !== x_en_u[i]) begin
                    n_fail++;
                    $display("FAIL run_en[%0d]: got cyc %0d up %b want cyc %0d up %b",
                             i, en_t[i], en_u[i], x_en_t[i], x_en_u[i]);
                end
            end
        end
        en_t.delete(); en_u.delete(); x_en_t.delete(); x_en_u.delete();
    endtask

    task automatic test_hold();
        int t0;
        int x;
        logic [2:0] v;
        x = m_next;
        while (x - D - 5 <= cyc) x += T;
        while (cyc < x - D - 5) @(negedge CLOCK_50);
        press(1, $urandom_range(D + 2, 10), t0);
        m_key1(t0 + D + 4);
        idle(D + 6);
        #1;
        n_run++;
        if (MODE !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_mode: got %b want 10", MODE);
        end
        v = 3'b101;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) v = 3'($urandom_range(0, 7));
            SW[3:1] = v;
            idle(4);
            press(0, $urandom_range(D + 2, 12), t0);
            m_key0(t0 + D + 4);
            idle(D + 6);
        end
        #1;
        n_run++;
        if (LOAD_VAL !== {5'b00000, v}) begin
            n_fail++;
            $display("FAIL hold_loadval: got %h want %h", LOAD_VAL, {5'b00000, v});
        end
        n_run++;
        if (ld_t.size() != x_ld_t.size() || en_t.size() != x_en_t.size()) begin
            n_fail++;
            $display("FAIL hold_counts: got ld %0d en %0d want ld %0d en %0d",
                     ld_t.size(), en_t.size(), x_ld_t.size(), x_en_t.size());
        end else begin
            foreach (x_ld_t[i]) begin
                n_run++;
                if (ld_t[i] !== x_ld_t[i] || ld_v[i] !== x_ld_v[i]) begin
                    n_fail++;
                    $display("FAIL hold_ld[%0d]: got cyc %0d val %h want cyc %0d val %h",
                             i, ld_t[i], ld_v[i], x_ld_t[i], x_ld_v[i]);
                end
            end
            foreach (x_en_t[i]) begin
                n_run++;
                if (en_t[i] !== x_en_t[i] || en_u[i] !== x_en_u[i]) begin
                    n_fail++;
                    $display("FAIL hold_en[%0d]: got cyc %0d up %b want cyc %0d up %b",
                             i, en_t[i], en_u[i], x_en_t[i], x_en_u[i]);
                end
            end
        end
        en_t.delete(); en_u.delete(); x_en_t.delete(); x_en_u.delete();
        ld_t.delete(); ld_v.delete(); x_ld_t.delete(); x_ld_v.delete();
        press(1, $urandom_range(D + 2, 10), t0);
        m_key1(t0 + D + 4);
        idle(D + 6);
        #1;
        n_run++;
        if (MODE !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_exit_mode: got %b want 00", MODE);
        end
    endtask

    task automatic test_both_keys();
        int t0;
        int h;
        h = $urandom_range(D + 2, D + 3);
        @(negedge CLOCK_50);
        KEY = 2'b00;
        t0 = cyc;
        repeat (h) @(negedge CLOCK_50);
        KEY = 2'b11;
        while (cyc < t0 + D + 3) @(negedge CLOCK_50);
        #1;
        n_run++;
        if (MODE !== 2'b00) begin
            n_fail++;
            $display("FAIL both_mode_early: got %b want 00", MODE);
        end
        @(negedge CLOCK_50);
        #1;
        n_run++;
        if (MODE !== 2'b01) begin
            n_fail++;
            $display("FAIL both_mode: got %b want 01", MODE);
        end
        m_key1(t0 + D + 4);
        idle(25);
        #1;
        m_flush(cyc);
        n_run++;
        if (en_t.size() != x_en_t.size()) begin
            n_fail++;
            $display("FAIL both_en_count: got %0d want %0d",
                     en_t.size(), x_en_t.size());
        end else begin
            foreach (x_en_t[i]) begin
                n_run++;
                if (en_t[i] !== x_en_t[i]) begin
                    n_fail++;
                    $display("FAIL both_en[%0d]: got cyc %0d want cyc %0d",
                             i, en_t[i], x_en_t[i]);
                end
            end
        end
        en_t.delete(); en_u.delete(); x_en_t.delete(); x_en_u.delete();
    endtask

    task automatic test_reset_mid_run();
        int t0;
        int target;
        m_flush(cyc);
        target = m_next + T - 1;
        while (cyc < target) @(negedge CLOCK_50);
        m_flush(target);
        RESET_N = 1'b0;
        #1;
        n_run++;
        if ({MODE, CNT_EN, CNT_LOAD, CNT_UP, LOAD_VAL} !== 13'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b want 0",
                     {MODE, CNT_EN, CNT_LOAD, CNT_UP, LOAD_VAL});
        end
        m_mode = 0;
        idle(2);
        RESET_N = 1'b1;
        idle(15);
        #1;
        n_run++;
        if (MODE !== 2'b00) begin
            n_fail++;
            $display("FAIL midrun_mode: got %b want 00", MODE);
        end
        press(0, $urandom_range(D + 2, 10), t0);
        m_key0(t0 + D + 4);
        idle(D + 6);
        #1;
        n_run++;
        if (en_t.size() != x_en_t.size()) begin
            n_fail++;
            $display("FAIL midrun_en_count: got %0d want %0d",
                     en_t.size(), x_en_t.size());
        end else begin
            foreach (x_en_t[i]) begin
                n_run++;
                if (en_t[i] !== x_en_t[i] || en_u[i] !== x_en_u[i]) begin
                    n_fail++;
                    $display("FAIL midrun_en[%0d]: got cyc %0d up %b want cyc %0d up %b",
                             i, en_t[i], en_u[i], x_en_t[i], x_en_u[i]);
                end
            end
        end
        en_t.delete(); en_u.delete(); x_en_t.delete(); x_en_u.delete();
    endtask

    task automatic test_exclusive();
        n_run++;
        if (both !== 0) begin
            n_fail++;
            $display("FAIL en_load_overlap: got %0d cycles want 0", both);
        end
    endtask

    initial begin
        test_reset();
        test_sw_sync();
        test_step();
        test_run();
        test_hold();
        test_both_keys();
        test_reset_mid_run();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
